// File: rtl/pueo_event_pkg.sv
// Shared framing definitions for the TURFIO event sender and the receiving accumulator.
// Frame type codes, control-word field positions and sender state encoding.
package pueo_event_pkg;

    localparam logic [3:0] FTYPE_HDR  = 4'h0;
    localparam logic [3:0] FTYPE_DATA = 4'h1;
    localparam logic [3:0] FTYPE_TRL  = 4'h2;

    localparam int CTL_TYPE_LSB  = 28;
    localparam int CTL_ADDR_LSB  = 16;
    localparam int CTL_CHUNK_LSB = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HCTL = 3'd1,
        ST_HLO  = 3'd2,
        ST_HHI  = 3'd3,
        ST_DCTL = 3'd4,
        ST_DATA = 3'd5,
        ST_TRL  = 3'd6
    } sender_state_t;

    // Word 0 of every frame: {type, addr, chunk, 8'h00}.
    function automatic logic [31:0] ctl_word(input logic [3:0]  ftype,
                                             input logic [11:0] addr,
                                             input logic [7:0]  chunk);
        logic [31:0] w;
        w = '0;
        w[CTL_TYPE_LSB  +: 4]  = ftype;
        w[CTL_ADDR_LSB  +: 12] = addr;
        w[CTL_CHUNK_LSB +: 8]  = chunk;
        return w;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-stage AXI4-Stream register (32-bit data + tlast).
// Holds its word stable until the downstream accepts it; loads whenever empty or draining.
module axis_out_reg (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] in_tdata,
    input  logic        in_tlast,
    input  logic        in_tvalid,
    output logic        in_tready,
    output logic [31:0] m_tdata,
    output logic        m_tlast,
    output logic        m_tvalid,
    input  logic        m_tready
);

    assign in_tready = !m_tvalid || m_tready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tdata  <= '0;
        end else if (in_tready) begin
            m_tvalid <= in_tvalid;
            if (in_tvalid) begin
                m_tdata <= in_tdata;
                m_tlast <= in_tlast;
            end
        end
    end

endmodule

// File: rtl/turfio_event_sender.sv
// Frames one event (64-bit header + payload stream) into header / data-chunk / trailer
// Aurora frames.
//
//  state | meaning
//  IDLE  | waiting for enable_i and a header
//  HCTL  | emit header control word (type 0)
//  HLO   | emit header bits [31:0]
//  HHI   | emit header bits [63:32], end of header frame
//  DCTL  | emit data control word (type 1) for the current chunk
//  DATA  | forward payload words, up to CHUNK_WORDS per frame
//  TRL   | emit trailer word (type 2) carrying the data frame count
module turfio_event_sender
    import pueo_event_pkg::*;
#(
    parameter int    CHUNK_WORDS = 256,
    parameter string ACLKTYPE    = "NONE"
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [63:0] s_hdr_tdata,
    input  logic        s_hdr_tvalid,
    output logic        s_hdr_tready,
    input  logic [31:0] s_data_tdata,
    input  logic        s_data_tvalid,
    output logic        s_data_tready,
    input  logic        s_data_tlast,
    output logic [31:0] m_aurora_tdata,
    output logic        m_aurora_tvalid,
    input  logic        m_aurora_tready,
    output logic        m_aurora_tlast,
    input  logic        enable_i,
    output logic        busy_o,
    output logic [15:0] event_count_o,
    output logic        err_o
);

    localparam int              WC_W    = $clog2(CHUNK_WORDS);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(CHUNK_WORDS - 1);

    sender_state_t   state, state_nxt;
    logic [63:0]     hdr_q;
    logic [7:0]      chunk_q;
    logic [WC_W-1:0] wc_q;
    logic [15:0]     evcnt_q;
    logic            err_q;
    logic            run_q;
    logic            enable;

    logic [31:0]     ld_data;
    logic            ld_last;
    logic            ld_valid;
    logic            ld_ready;
    logic            ld_fire;
    logic [7:0]      trl_count;

    // Registers tagged as crossing from another domain get their enable resynchronised.
    if (ACLKTYPE == "NONE") begin : g_en_direct
        assign enable = enable_i;
    end else begin : g_en_sync
        logic [1:0] en_sync;
        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) en_sync <= 2'b00;
            else          en_sync <= {en_sync[0], enable_i};
        end
        assign enable = en_sync[1];
    end

    assign trl_count = (chunk_q == 8'hFF) ? 8'hFF : chunk_q + 8'd1;
    assign ld_fire   = ld_valid && ld_ready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        s_hdr_tready  = 1'b0;
        s_data_tready = 1'b0;
        ld_valid      = 1'b0;
        ld_data       = '0;
        ld_last       = 1'b0;
        case (state)
            ST_IDLE: begin
                // run_q keeps the first acceptance off the release edge.
                if (run_q && enable && s_hdr_tvalid) begin
                    s_hdr_tready = 1'b1;
                    state_nxt    = ST_HCTL;
                end
            end
            ST_HCTL: begin
                ld_valid = 1'b1;
                ld_data  = ctl_word(FTYPE_HDR, hdr_q[11:0], 8'h00);
                if (ld_ready) state_nxt = ST_HLO;
            end
            ST_HLO: begin
                ld_valid = 1'b1;
                ld_data  = hdr_q[31:0];
                if (ld_ready) state_nxt = ST_HHI;
            end
            ST_HHI: begin
                ld_valid = 1'b1;
                ld_data  = hdr_q[63:32];
                ld_last  = 1'b1;
                if (ld_ready) state_nxt = ST_DCTL;
            end
            ST_DCTL: begin
                ld_valid = 1'b1;
                ld_data  = ctl_word(FTYPE_DATA, hdr_q[11:0], chunk_q);
                if (ld_ready) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                s_data_tready = ld_ready;
                ld_valid      = s_data_tvalid;
                ld_data       = s_data_tdata;
                ld_last       = s_data_tlast || (wc_q == WC_LAST);
                // Payload end wins over chunk end so no empty data frame is produced.
                if (s_data_tvalid && ld_ready) begin
                    if (s_data_tlast)         state_nxt = ST_TRL;
                    else if (wc_q == WC_LAST) state_nxt = ST_DCTL;
                end
            end
            ST_TRL: begin
                ld_valid = 1'b1;
                ld_data  = ctl_word(FTYPE_TRL, hdr_q[11:0], trl_count);
                ld_last  = 1'b1;
                if (ld_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hdr_q   <= '0;
            chunk_q <= '0;
            wc_q    <= '0;
            evcnt_q <= '0;
            err_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (s_hdr_tready) begin
                hdr_q   <= s_hdr_tdata;
                chunk_q <= '0;
            end
            if (state == ST_DCTL && ld_fire) wc_q <= '0;
            if (state == ST_DATA && ld_fire) begin
                wc_q <= wc_q + WC_W'(1);
                if (!s_data_tlast && wc_q == WC_LAST) begin
                    // Chunk field saturates; the overflow is reported, framing carries on.
                    if (chunk_q == 8'hFF) err_q   <= 1'b1;
                    else                  chunk_q <= chunk_q + 8'd1;
                end
            end
            if (state == ST_TRL && ld_fire) evcnt_q <= evcnt_q + 16'd1;
        end
    end

    axis_out_reg u_out (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_tdata  (ld_data),
        .in_tlast  (ld_last),
        .in_tvalid (ld_valid),
        .in_tready (ld_ready),
        .m_tdata   (m_aurora_tdata),
        .m_tlast   (m_aurora_tlast),
        .m_tvalid  (m_aurora_tvalid),
        .m_tready  (m_aurora_tready)
    );

    assign busy_o        = (state != ST_IDLE);
    assign event_count_o = evcnt_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_turfio_event_sender.sv
// Directed bench for turfio_event_sender with CHUNK_WORDS=16.
module tb_turfio_event_sender;

    localparam int CW = 16;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [63:0] s_hdr_tdata;
    logic        s_hdr_tvalid;
    logic        s_hdr_tready;
    logic [31:0] s_data_tdata;
    logic        s_data_tvalid;
    logic        s_data_tready;
    logic        s_data_tlast;
    logic [31:0] m_aurora_tdata;
    logic        m_aurora_tvalid;
    logic        m_aurora_tready;
    logic        m_aurora_tlast;
    logic        enable_i;
    logic        busy_o;
    logic [15:0] event_count_o;
    logic        err_o;

    turfio_event_sender #(.CHUNK_WORDS(CW), .ACLKTYPE("NONE")) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .s_hdr_tdata     (s_hdr_tdata),
        .s_hdr_tvalid    (s_hdr_tvalid),
        .s_hdr_tready    (s_hdr_tready),
        .s_data_tdata    (s_data_tdata),
        .s_data_tvalid   (s_data_tvalid),
        .s_data_tready   (s_data_tready),
        .s_data_tlast    (s_data_tlast),
        .m_aurora_tdata  (m_aurora_tdata),
        .m_aurora_tvalid (m_aurora_tvalid),
        .m_aurora_tready (m_aurora_tready),
        .m_aurora_tlast  (m_aurora_tlast),
        .enable_i        (enable_i),
        .busy_o          (busy_o),
        .event_count_o   (event_count_o),
        .err_o           (err_o)
    );

    always #5 aclk = ~aclk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [32:0] got_q[$];
    logic [32:0] exp_q[$];
    int          cap_cyc[$];
    int          cyc_cnt = 0;
    int          stall_viol = 0;
    logic        prev_stall = 1'b0;
    logic [32:0] prev_word = '0;
    int          ev_id = 0;

    // Output monitor: captures accepted words and checks stability under backpressure.
    always @(negedge aclk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (!aresetn) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!m_aurora_tvalid || {m_aurora_tlast, m_aurora_tdata} !== prev_word))
                stall_viol <= stall_viol + 1;
            if (m_aurora_tvalid && m_aurora_tready) begin
                got_q.push_back({m_aurora_tlast, m_aurora_tdata});
                cap_cyc.push_back(cyc_cnt);
            end
            prev_stall <= m_aurora_tvalid && !m_aurora_tready;
            prev_word  <= {m_aurora_tlast, m_aurora_tdata};
        end
    end

    function automatic logic [31:0] dword(input int ev, input int i);
        return {8'hA5, ev[7:0], i[15:0]};
    endfunction

    task automatic model_event(input logic [63:0] hdr, input int ev, input int n);
        logic [11:0] a;
        int          nch;
        int          c;
        a   = hdr[11:0];
        nch = (n + CW - 1) / CW;
        exp_q.push_back({1'b0, 4'h0, a, 8'h00, 8'h00});
        exp_q.push_back({1'b0, hdr[31:0]});
        exp_q.push_back({1'b1, hdr[63:32]});
        for (int i = 0; i < n; i++) begin
            if (i % CW == 0) begin
                c = i / CW;
                exp_q.push_back({1'b0, 4'h1, a, (c > 255) ? 8'hFF : c[7:0], 8'h00});
            end
            exp_q.push_back({((i == n - 1) || (i % CW == CW - 1)) ? 1'b1 : 1'b0, dword(ev, i)});
        end
        exp_q.push_back({1'b1, 4'h2, a, (nch > 255) ? 8'hFF : nch[7:0], 8'h00});
    endtask

    task automatic clear_queues();
        got_q.delete();
        exp_q.delete();
        cap_cyc.delete();
    endtask

    // Drives one event; entered and left at posedge+1.
    task automatic run_event(input logic [63:0] hdr, input int n, input bit rnd,
                             input int en_drop_at, input int abort_at);
        int idx;
        int cyc;
        int budget;
        bit hs_h;
        bit hs_d;
        idx    = 0;
        cyc    = 0;
        budget = 8 * n + 200;
        model_event(hdr, ev_id, n);
        s_hdr_tdata   = hdr;
        s_hdr_tvalid  = 1'b1;
        s_data_tvalid = (n > 0);
        s_data_tdata  = dword(ev_id, 0);
        s_data_tlast  = (n == 1);
        while (got_q.size() < exp_q.size() && cyc < budget) begin
            if (abort_at >= 0 && idx == abort_at) break;
            m_aurora_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (idx == en_drop_at) enable_i = 1'b0;
            @(negedge aclk);
            hs_h = s_hdr_tvalid && s_hdr_tready;
            hs_d = s_data_tvalid && s_data_tready;
            @(posedge aclk);
            #1;
            cyc++;
            if (hs_h) s_hdr_tvalid = 1'b0;
            if (hs_d) begin
                idx++;
                if (idx < n) begin
                    s_data_tdata = dword(ev_id, idx);
                    s_data_tlast = (idx == n - 1);
                end else begin
                    s_data_tvalid = 1'b0;
                    s_data_tlast  = 1'b0;
                end
            end
        end
        m_aurora_tready = 1'b1;
        ev_id++;
        if (abort_at < 0) begin
            n_tests++;
            if (got_q.size() < exp_q.size()) begin
                n_fail++;
                $display("FAIL event_timeout: got %0d words, required %0d", got_q.size(), exp_q.size());
            end
        end
    endtask

    task automatic test_reset();
        aresetn       = 1'b0;
        enable_i      = 1'b1;
        s_hdr_tvalid  = 1'b1;
        s_hdr_tdata   = 64'h0;
        s_data_tvalid = 1'b1;
        s_data_tdata  = '0;
        s_data_tlast  = 1'b0;
        m_aurora_tready = 1'b1;
        repeat (3) @(negedge aclk);
        n_tests++;
        if ({m_aurora_tvalid, m_aurora_tlast, m_aurora_tdata} !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_out: got %h required 0", {m_aurora_tvalid, m_aurora_tlast, m_aurora_tdata});
        end
        n_tests++;
        if ({s_hdr_tready, s_data_tready, busy_o, err_o} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b required 0000", {s_hdr_tready, s_data_tready, busy_o, err_o});
        end
        n_tests++;
        if (event_count_o !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d required 0", event_count_o);
        end
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(negedge aclk);
        n_tests++;
        if (s_hdr_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL release_hdr_ready: got %b required 0", s_hdr_tready);
        end
        s_hdr_tvalid  = 1'b0;
        s_data_tvalid = 1'b0;
        @(posedge aclk);
        #1;
    endtask

    task automatic test_basic();
        int          mism;
        logic [32:0] w;
        clear_queues();
        run_event(64'h0000_0000_DEAD_B123, 20, 1'b0, -1, -1);
        mism = -1;
        if (got_q.size() == exp_q.size())
            foreach (exp_q[i]) if (mism < 0 && got_q[i] !== exp_q[i]) mism = i;
        n_tests++;
        if (got_q.size() != exp_q.size() || mism >= 0) begin
            n_fail++;
            $display("FAIL basic_stream: got %0d words (first bad %0d) required %0d words",
                     got_q.size(), mism, exp_q.size());
        end
        w = got_q[0];
        n_tests++;
        if (w[31:0] !== 32'h0123_0000) begin
            n_fail++;
            $display("FAIL basic_hdr_ctl: got %h required 01230000", w[31:0]);
        end
        w = got_q[20];
        n_tests++;
        if (w[31:0] !== 32'h1123_0100) begin
            n_fail++;
            $display("FAIL basic_chunk1_ctl: got %h required 11230100", w[31:0]);
        end
        w = got_q[25];
        n_tests++;
        if (w !== {1'b1, 32'h2123_0200}) begin
            n_fail++;
            $display("FAIL basic_trailer: got %h required 1_21230200", w);
        end
        n_tests++;
        if (cap_cyc.size() != 26 || cap_cyc[25] - cap_cyc[0] != 25) begin
            n_fail++;
            $display("FAIL basic_throughput: got %0d words over %0d cycles required 26 over 25",
                     cap_cyc.size(), (cap_cyc.size() > 0) ? cap_cyc[cap_cyc.size()-1] - cap_cyc[0] : -1);
        end
        n_tests++;
        if (event_count_o !== 16'd1) begin
            n_fail++;
            $display("FAIL basic_count: got %0d required 1", event_count_o);
        end
    endtask

    task automatic test_exact_chunk();
        int          mism;
        logic [32:0] w;
        clear_queues();
        run_event(64'h1111_2222_3333_4456, 16, 1'b0, -1, -1);
        mism = -1;
        if (got_q.size() == exp_q.size())
            foreach (exp_q[i]) if (mism < 0 && got_q[i] !== exp_q[i]) mism = i;
        n_tests++;
        if (got_q.size() != exp_q.size() || mism >= 0) begin
            n_fail++;
            $display("FAIL exact_stream: got %0d words (first bad %0d) required %0d words",
                     got_q.size(), mism, exp_q.size());
        end
        w = got_q[19];
        n_tests++;
        if (w[32] !== 1'b1) begin
            n_fail++;
            $display("FAIL exact_word16_tlast: got %b required 1", w[32]);
        end
        w = got_q[20];
        n_tests++;
        if (w !== {1'b1, 32'h2456_0100} || got_q.size() != 21) begin
            n_fail++;
            $display("FAIL exact_trailer: got %h (%0d words) required 1_24560100 (21 words)", w, got_q.size());
        end
        n_tests++;
        if (event_count_o !== 16'd2) begin
            n_fail++;
            $display("FAIL exact_count: got %0d required 2", event_count_o);
        end
    endtask

    task automatic test_random_ready();
        int mism;
        clear_queues();
        stall_viol = 0;
        for (int e = 0; e < 100; e++)
            run_event({$urandom(), $urandom()}, int'($urandom_range(1, 40)), 1'b1, -1, -1);
        mism = -1;
        if (got_q.size() == exp_q.size())
            foreach (exp_q[i]) if (mism < 0 && got_q[i] !== exp_q[i]) mism = i;
        n_tests++;
        if (got_q.size() != exp_q.size() || mism >= 0) begin
            n_fail++;
            $display("FAIL random_stream: got %0d words (first bad %0d) required %0d words",
                     got_q.size(), mism, exp_q.size());
        end
        n_tests++;
        if (stall_viol != 0) begin
            n_fail++;
            $display("FAIL random_stable: got %0d violations required 0", stall_viol);
        end
        n_tests++;
        if (event_count_o !== 16'd102 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL random_count: got %0d err %b required 102 err 0", event_count_o, err_o);
        end
    endtask

    task automatic test_enable_gate();
        int mism;
        int early;
        clear_queues();
        run_event(64'hCAFE_0000_0000_0777, 20, 1'b0, 5, -1);
        mism = -1;
        if (got_q.size() == exp_q.size())
            foreach (exp_q[i]) if (mism < 0 && got_q[i] !== exp_q[i]) mism = i;
        n_tests++;
        if (got_q.size() != exp_q.size() || mism >= 0) begin
            n_fail++;
            $display("FAIL enable_event1: got %0d words (first bad %0d) required %0d words",
                     got_q.size(), mism, exp_q.size());
        end
        s_hdr_tdata  = 64'h0;
        s_hdr_tvalid = 1'b1;
        early = 0;
        repeat (20) begin
            @(negedge aclk);
            if (s_hdr_tready || busy_o) early++;
        end
        @(posedge aclk);
        #1;
        n_tests++;
        if (early != 0) begin
            n_fail++;
            $display("FAIL enable_hold: got %0d accepting cycles required 0", early);
        end
        enable_i = 1'b1;
        clear_queues();
        run_event(64'h0000_0000_0000_0778, 3, 1'b0, -1, -1);
        mism = -1;
        if (got_q.size() == exp_q.size())
            foreach (exp_q[i]) if (mism < 0 && got_q[i] !== exp_q[i]) mism = i;
        n_tests++;
        if (got_q.size() != exp_q.size() || mism >= 0 || event_count_o !== 16'd104) begin
            n_fail++;
            $display("FAIL enable_event2: got %0d words (first bad %0d) count %0d required %0d words count 104",
                     got_q.size(), mism, exp_q.size(), event_count_o);
        end
    endtask

    task automatic test_reset_mid();
        int          mism;
        logic [32:0] w;
        clear_queues();
        run_event(64'h0000_0000_0000_0345, 30, 1'b0, -1, 20);
        s_hdr_tdata  = 64'h0;
        s_hdr_tvalid = 1'b1;
        aresetn      = 1'b0;
        #1;
        n_tests++;
        if ({m_aurora_tvalid, m_aurora_tlast, m_aurora_tdata, s_hdr_tready, s_data_tready,
             busy_o, event_count_o, err_o} !== 53'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got tv%b tl%b td%h hr%b dr%b busy%b cnt%0d err%b required all 0",
                     m_aurora_tvalid, m_aurora_tlast, m_aurora_tdata, s_hdr_tready, s_data_tready,
                     busy_o, event_count_o, err_o);
        end
        s_hdr_tvalid  = 1'b0;
        s_data_tvalid = 1'b0;
        s_data_tlast  = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        clear_queues();
        run_event(64'h0000_0000_9876_5ABC, 5, 1'b0, -1, -1);
        mism = -1;
        if (got_q.size() == exp_q.size())
            foreach (exp_q[i]) if (mism < 0 && got_q[i] !== exp_q[i]) mism = i;
        w = got_q[0];
        n_tests++;
        if (got_q.size() != exp_q.size() || mism >= 0 || w !== {1'b0, 32'h0ABC_0000}) begin
            n_fail++;
            $display("FAIL midreset_restart: got %0d words first %h (bad %0d) required %0d words first 0_0abc0000",
                     got_q.size(), w, mism, exp_q.size());
        end
        n_tests++;
        if (event_count_o !== 16'd1) begin
            n_fail++;
            $display("FAIL midreset_count: got %0d required 1", event_count_o);
        end
    endtask

    task automatic test_overflow();
        int          mism;
        logic [32:0] w;
        clear_queues();
        n_tests++;
        if (err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_pre_err: got %b required 0", err_o);
        end
        run_event(64'h0000_0001_0000_0ABC, 4112, 1'b0, -1, -1);
        mism = -1;
        if (got_q.size() == exp_q.size())
            foreach (exp_q[i]) if (mism < 0 && got_q[i] !== exp_q[i]) mism = i;
        n_tests++;
        if (got_q.size() != exp_q.size() || mism >= 0) begin
            n_fail++;
            $display("FAIL overflow_stream: got %0d words (first bad %0d) required %0d words",
                     got_q.size(), mism, exp_q.size());
        end
        w = got_q[got_q.size() - 1];
        n_tests++;
        if (w !== {1'b1, 32'h2ABC_FF00}) begin
            n_fail++;
            $display("FAIL overflow_trailer: got %h required 1_2abcff00", w);
        end
        n_tests++;
        if (err_o !== 1'b1 || event_count_o !== 16'd2) begin
            n_fail++;
            $display("FAIL overflow_err: got err %b count %0d required err 1 count 2", err_o, event_count_o);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_exact_chunk();
        test_random_ready();
        test_enable_gate();
        test_reset_mid();
        test_overflow();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
